kamacore_dmem_arbiter: RTL
==========================

KAMACORE_DMEM_ARBITER -- requirements
Module: kamacore_dmem_arbiter

Interface
REQ-001 Parameter CPU_WIDTH, default 32: data and address width of all ports.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive denied port-1 cycles before port 1 is forced a grant; legal range 1-15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 p0_req  input  1  pipeline memory stage requests an access this cycle.
REQ-006 p0_we  input  1  port-0 access is a write.
REQ-007 p0_addr  input  CPU_WIDTH  port-0 address.
REQ-008 p0_wdata  input  CPU_WIDTH  port-0 write data.
REQ-009 p0_gnt  output  1  port-0 access performed this cycle (combinational).
REQ-010 p0_rvalid  output  1  port-0 read data valid (registered).
REQ-011 p0_rdata  output  CPU_WIDTH  port-0 read data (registered).
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same directions, widths and meanings for the debug/loader port.
REQ-013 mem_we  output  1  data memory write enable.
REQ-014 mem_a  output  CPU_WIDTH  data memory address.
REQ-015 mem_di  output  CPU_WIDTH  data memory write data.
REQ-016 mem_spo  input  CPU_WIDTH  data memory asynchronous read data at mem_a.
REQ-017 stall  output  1  pipeline must hold the memory stage this cycle.

Function
REQ-018 At most one of p0_gnt and p1_gnt shall be 1 in any cycle; gnt=1 only when the corresponding req=1.
REQ-019 Default priority: p0 granted whenever p0_req=1, unless the starvation override is active.
REQ-020 Starvation counter (4 bits) increments each cycle p1_req=1 and p1_gnt=0, clears on any p1_gnt or any cycle with p1_req=0, and saturates at STARVE_LIMIT.
REQ-021 Override active when counter == STARVE_LIMIT: p1 granted that cycle even if p0_req=1; the counter clears next edge.
REQ-022 Only p0_req=0 with p1_req=1 grants p1 outside an override.
REQ-023 mem_we/mem_a/mem_di mirror the granted port's we/addr/wdata; no grant -> mem_we=0, mem_a/mem_di=0.
REQ-024 mem_we shall never be 1 without a grant.
REQ-025 Read grant (we=0) in cycle N: mem_spo is captured at edge N; pX_rvalid=1 for exactly cycle N+1 with pX_rdata = captured value.
REQ-026 Write grant shall not raise rvalid.
REQ-027 pX_rdata holds its last value while rvalid=0.
REQ-028 stall = p0_req & ~p0_gnt.
REQ-029 Back-to-back grants to either port in consecutive cycles are permitted; throughput 1 access/cycle.
REQ-030 Requests are not queued: a denied requester must hold req and payload until gnt; the arbiter shall not latch ungranted payloads.

Reset
REQ-031 While rst=0 at an edge: counter=0, p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
REQ-032 A read granted in the cycle reset is asserted shall produce no rvalid after reset.
REQ-033 Combinational outputs (gnt, mem_*, stall) follow REQ-018..028 during reset; the counter is treated as 0.

Verification
REQ-034 p0 read addr 0x10, mem_spo=0xDEADBEEF, p1 idle -> p0_gnt=1, mem_a=0x10, stall=0; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF.
REQ-035 p0 and p1 both request every cycle, STARVE_LIMIT=4 -> p0 granted cycles 0-3, p1 granted cycle 4 with stall=1, p0 granted cycles 5-8, p1 granted cycle 9.
REQ-036 p1 write addr 0x20 data 0x55 with p0_req=0 -> p1_gnt=1, mem_we=1, mem_a=0x20, mem_di=0x55; no rvalid next cycle.
REQ-037 p1 requests 3 cycles, drops 1 cycle, then requests alongside p0 -> counter restarts at 0; p1 forced only after 4 further denied cycles.
REQ-038 p0 read granted in the same cycle rst=0 -> p0_rvalid=0, p0_rdata=0 after the edge; counter=0.
REQ-039 Alternate p0 read 0x4 / p1 read 0x8 on consecutive cycles -> each rvalid appears one cycle after its grant with the matching data; never both rvalid in one cycle.

Source files
------------

// File: rtl/kamacore_dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline port 0 has priority, debug/loader port 1 gets a forced grant after STARVE_LIMIT denials.
// Grants and memory-side signals are combinational; read data returns registered one cycle after the grant. Denied requesters hold their request.
module kamacore_dmem_arbiter #(
    parameter int CPU_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [CPU_WIDTH-1:0] p0_addr,
    input  logic [CPU_WIDTH-1:0] p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_rvalid,
    output logic [CPU_WIDTH-1:0] p0_rdata,

    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [CPU_WIDTH-1:0] p1_addr,
    input  logic [CPU_WIDTH-1:0] p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_rvalid,
    output logic [CPU_WIDTH-1:0] p1_rdata,

    output logic                 mem_we,
    output logic [CPU_WIDTH-1:0] mem_a,
    output logic [CPU_WIDTH-1:0] mem_di,
    input  logic [CPU_WIDTH-1:0] mem_spo,

    output logic                 stall
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       starve_override;

    // A stale count is ignored while reset is held so grants follow plain priority.
    assign starve_override = rst & (starve_cnt == LIMIT);

    always_comb begin
        p1_gnt = p1_req & (starve_override | ~p0_req);
        p0_gnt = p0_req & ~p1_gnt;
        stall  = p0_req & ~p0_gnt;
    end

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_di = '0;
        if (p0_gnt) begin
            mem_we = p0_we;
            mem_a  = p0_addr;
            mem_di = p0_wdata;
        end else if (p1_gnt) begin
            mem_we = p1_we;
            mem_a  = p1_addr;
            mem_di = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!p1_req || p1_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read data is captured from the asynchronous memory at the grant edge; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_spo;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_spo;
            end
        end
    end

endmodule
